// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding, default width and the half-subtractor bit function.
package serial_subtractor_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Returns {borrow, difference} for a single bit pair.
    function automatic logic [1:0] half_sub(
        input logic x,
        input logic y
    );
        return {~x & y, x ^ y};
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
// Optional ovf signal exists only with SERIAL_SUBTRACTOR_OVF_EN.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;

    modport master (
        output start, a_in, b_in, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a_in, b_in, bin,
        output busy, done, diff, bout, ovf
    );
`else
    modport master (
        output start, a_in, b_in, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a_in, b_in, bin,
        output busy, done, diff, bout
    );
`endif

endinterface

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor: two half-subtractor stages plus an OR.
// Purely combinational; the caller registers the borrow.
module serial_sub_cell
    import serial_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic [1:0] hs0;
    logic [1:0] hs1;

    assign hs0 = half_sub(a, b);
    assign hs1 = half_sub(hs0[0], bin);

    assign d  = hs1[0];
    assign bo = hs0[1] | hs1[1];

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed overflow flag.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_r;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             bout_r;
    logic             d;
    logic             bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_r;
`endif

    serial_sub_cell u_cell (
        .a   (a_reg[0]),
        .b   (b_reg[0]),
        .bin (br),
        .d   (d),
        .bo  (bo)
    );

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign bus.ovf  = ovf_r;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            diff_r <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            bout_r <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_reg  <= bus.a_in;
                        b_reg  <= bus.b_in;
                        br     <= bus.bin;
                        cnt    <= '0;
                        diff_r <= '0;
                        state  <= SHIFT;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    diff_r <= {d, diff_r[WIDTH-1:1]};
                    a_reg  <= {1'b0, a_reg[WIDTH-1:1]};
                    b_reg  <= {1'b0, b_reg[WIDTH-1:1]};
                    br     <= bo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bout_r <= bo;
                        state  <= DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        // a_reg[0]/b_reg[0] now hold the operand MSBs
                        ovf_r  <= (a_reg[0] ^ b_reg[0])
                                & (d ^ a_reg[0]);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Covers ovf checks when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    serial_subtractor_if #(.WIDTH(8)) bus ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_ovf();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Issues one operation from idle and waits (bounded) for done.
    task automatic run_op(
        input  logic [7:0] a,
        input  logic [7:0] b,
        input  logic       bi,
        output int         lat,
        output int         nbusy,
        output logic [7:0] d,
        output logic       bo,
        output logic       ov,
        output bit         tmo
    );
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.bin   = bi;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat   = 0;
        nbusy = bus.busy ? 1 : 0;
        tmo   = 1'b1;
        d     = '0;
        bo    = 1'b0;
        ov    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) nbusy++;
            if (bus.done) begin
                d   = bus.diff;
                bo  = bus.bout;
                ov  = get_ovf();
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        n_vec++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done got %b want 0", bus.done);
        end
        n_vec++;
        if (bus.diff !== 8'h00 || bus.bout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_diff got %h/%b want 00/0",
                     bus.diff, bus.bout);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, nb;
        logic [7:0] d;
        logic bo, ov;
        bit tmo;
        run_op(8'h35, 8'h12, 1'b0, lat, nb, d, bo, ov, tmo);
        n_vec++;
        if (tmo || lat !== 8) begin
            n_err++;
            $display("FAIL basic_latency got %0d (tmo=%0b) want 8",
                     lat, tmo);
        end
        n_vec++;
        if (nb !== 8) begin
            n_err++;
            $display("FAIL basic_busy_cycles got %0d want 8", nb);
        end
        n_vec++;
        if (d !== 8'h23 || bo !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result got %h/%b want 23/0", d, bo);
        end
    endtask

    task automatic test_borrow();
        int lat, nb;
        logic [7:0] d;
        logic bo, ov;
        bit tmo;
        run_op(8'h00, 8'h01, 1'b0, lat, nb, d, bo, ov, tmo);
        n_vec++;
        if (tmo || d !== 8'hFF || bo !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_result got %h/%b want ff/1", d, bo);
        end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        n_vec++;
        if (ov !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_ovf got %b want 0", ov);
        end
`endif
        run_op(8'h10, 8'h10, 1'b1, lat, nb, d, bo, ov, tmo);
        n_vec++;
        if (tmo || d !== 8'hFF || bo !== 1'b1) begin
            n_err++;
            $display("FAIL bin_result got %h/%b want ff/1", d, bo);
        end
        run_op(8'h80, 8'h01, 1'b0, lat, nb, d, bo, ov, tmo);
        n_vec++;
        if (tmo || d !== 8'h7F || bo !== 1'b0) begin
            n_err++;
            $display("FAIL msb_result got %h/%b want 7f/0", d, bo);
        end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        n_vec++;
        if (ov !== 1'b1) begin
            n_err++;
            $display("FAIL msb_ovf got %b want 1", ov);
        end
`endif
    endtask

    task automatic test_ignore_busy();
        int lat;
        bit tmo;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 8'h35;
        bus.b_in  = 8'h12;
        bus.bin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 8'hAA;
        bus.b_in  = 8'h00;
        bus.bin   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 3;
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                tmo = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        n_vec++;
        if (tmo || lat !== 8) begin
            n_err++;
            $display("FAIL ignore_latency got %0d (tmo=%0b) want 8",
                     lat, tmo);
        end
        n_vec++;
        if (bus.diff !== 8'h23 || bus.bout !== 1'b0) begin
            n_err++;
            $display("FAIL ignore_result got %h/%b want 23/0",
                     bus.diff, bus.bout);
        end
    endtask

    task automatic test_async_reset();
        int lat, nb;
        logic [7:0] d;
        logic bo, ov;
        bit tmo;
        bit saw_done;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 8'hFF;
        bus.b_in  = 8'h0F;
        bus.bin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL arst_ctrl got busy=%b done=%b want 0/0",
                     bus.busy, bus.done);
        end
        n_vec++;
        if (bus.diff !== 8'h00 || bus.bout !== 1'b0) begin
            n_err++;
            $display("FAIL arst_data got %h/%b want 00/0",
                     bus.diff, bus.bout);
        end
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL arst_no_done got 1 want 0");
        end
        run_op(8'h9C, 8'h47, 1'b0, lat, nb, d, bo, ov, tmo);
        n_vec++;
        if (tmo || d !== 8'h55 || bo !== 1'b0) begin
            n_err++;
            $display("FAIL arst_after got %h/%b want 55/0", d, bo);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nb;
        logic [7:0] d;
        logic bo, ov;
        bit tmo;
        run_op(8'h35, 8'h12, 1'b0, lat, nb, d, bo, ov, tmo);
        bus.start = 1'b1;
        bus.a_in  = 8'h05;
        bus.b_in  = 8'h03;
        bus.bin   = 1'b0;
        n_vec++;
        if (tmo || bus.done !== 1'b1 || bus.diff !== 8'h23) begin
            n_err++;
            $display("FAIL b2b_first got done=%b diff=%h want 1/23",
                     bus.done, bus.diff);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_nogap got busy=%b done=%b want 1/0",
                     bus.busy, bus.done);
        end
        n_vec++;
        if (bus.diff !== 8'h00) begin
            n_err++;
            $display("FAIL b2b_clear got %h want 00", bus.diff);
        end
        lat = 0;
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) begin
                tmo = 1'b0;
                break;
            end
        end
        n_vec++;
        if (tmo || lat !== 8) begin
            n_err++;
            $display("FAIL b2b_latency got %0d (tmo=%0b) want 8",
                     lat, tmo);
        end
        n_vec++;
        if (bus.diff !== 8'h02 || bus.bout !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_result got %h/%b want 02/0",
                     bus.diff, bus.bout);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.bin   = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_ignore_busy();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
